// File: rtl/min_max_tracker_pkg.sv
// Shared state encoding and default widths for the min/max tracker.
// Optional build macro: MIN_MAX_TRACKER_SIGNED_EN selects two's complement comparison.
package min_max_tracker_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/min_max_tracker_mag_cmp.sv
// Combinational magnitude comparator: reports a<b, a>b, a==b.
// MIN_MAX_TRACKER_SIGNED_EN selects two's complement operands; unsigned otherwise.
module mag_cmp #(
  parameter int unsigned DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              lt,
  output logic              gt,
  output logic              eq
);

  // Ordering flags for the selected number representation.
  always_comb begin
`ifdef MIN_MAX_TRACKER_SIGNED_EN
    lt = $signed(a) < $signed(b);
    gt = $signed(a) > $signed(b);
`else
    lt = a < b;
    gt = a > b;
`endif
    eq = (a == b);
  end

endmodule

// File: rtl/min_max_tracker.sv
// Frame-based running min/max tracker with valid/ready on both sides.
// Optional build macro: MIN_MAX_TRACKER_SIGNED_EN (signed sample comparison).
module min_max_tracker
  import min_max_tracker_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_all_eq
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              all_eq_q, all_eq_d;
  logic              out_valid_q, out_valid_d;

  logic lt_min, gt_min, eq_min;
  logic lt_max, gt_max, eq_max;
  logic accept;
  logic unused_cmp;

  mag_cmp #(.DATA_W(DATA_W)) u_cmp_min (
    .a  (in_data),
    .b  (min_q),
    .lt (lt_min),
    .gt (gt_min),
    .eq (eq_min)
  );

  mag_cmp #(.DATA_W(DATA_W)) u_cmp_max (
    .a  (in_data),
    .b  (max_q),
    .lt (lt_max),
    .gt (gt_max),
    .eq (eq_max)
  );

  // Only the "new extreme" and equality flags drive updates.
  assign unused_cmp = gt_min ^ lt_max;

  assign in_ready = (state_q != ST_HOLD);
  assign accept   = in_valid & in_ready;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    max_d       = max_q;
    count_d     = count_q;
    all_eq_d    = all_eq_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          min_d    = in_data;
          max_d    = in_data;
          count_d  = CNT_W'(1);
          all_eq_d = 1'b1;
          if (in_last) begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          if (lt_min) min_d = in_data;
          if (gt_max) max_d = in_data;
          if (!(eq_min && eq_max)) all_eq_d = 1'b0;
          if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
          if (in_last) begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and result registers; reset drops any partial or held frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      min_q       <= '0;
      max_q       <= '0;
      count_q     <= '0;
      all_eq_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      max_q       <= max_d;
      count_q     <= count_d;
      all_eq_q    <= all_eq_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_min    = min_q;
  assign out_max    = max_q;
  assign out_count  = count_q;
  assign out_all_eq = all_eq_q;

endmodule

// File: tb/tb_min_max_tracker.sv
// Directed bench for min_max_tracker with a reference model and result scoreboard.
// Runs a second instance with CNT_W=3 on the same stimulus to cover count saturation.
module tb_min_max_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       in_ready, out_valid, out_all_eq;
  logic [3:0] out_min, out_max;
  logic [7:0] out_count;

  logic       in_ready_s, out_valid_s, out_all_eq_s;
  logic [3:0] out_min_s, out_max_s;
  logic [2:0] out_count_s;

  always #5 clk = ~clk;

  min_max_tracker #(.DATA_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_max(out_max), .out_count(out_count), .out_all_eq(out_all_eq)
  );

  min_max_tracker #(.DATA_W(4), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_min(out_min_s), .out_max(out_max_s), .out_count(out_count_s), .out_all_eq(out_all_eq_s)
  );

  typedef struct packed {
    logic [3:0] mn;
    logic [3:0] mx;
    logic [7:0] cnt;
    logic [2:0] cnt_s;
    logic       eq;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [3:0] m_min, m_max;
  int         m_cnt;
  logic       m_eq;
  bit         m_first = 1'b1;

  function automatic bit less(input logic [3:0] a, input logic [3:0] b);
`ifdef MIN_MAX_TRACKER_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [3:0] d, input logic last);
    exp_t e;
    if (m_first) begin
      m_min = d; m_max = d; m_cnt = 1; m_eq = 1'b1; m_first = 1'b0;
    end else begin
      if (d != m_min || d != m_max) m_eq = 1'b0;
      if (less(d, m_min)) m_min = d;
      if (less(m_max, d)) m_max = d;
      m_cnt++;
    end
    if (last) begin
      e.mn    = m_min;
      e.mx    = m_max;
      e.cnt   = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
      e.cnt_s = (m_cnt > 7) ? 3'd7 : 3'(m_cnt);
      e.eq    = m_eq;
      sb.push_back(e);
      m_first = 1'b1;
    end
  endtask

  // Drive one beat (called #1 after a posedge); returns #1 after the accepting edge.
  task automatic beat(input logic [3:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    model_accept(d, last);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (last) begin
      @(negedge clk);
      check("latency_out_valid", 32'(out_valid), 32'd1);
    end
  endtask

  // Wait (bounded) for a result, compare against the scoreboard, then handshake.
  task automatic get_result(input string tag);
    exp_t e;
    int   n = 0;
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      check({tag, "_timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      check({tag, "_unexpected"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_min"},     32'(out_min),     32'(e.mn));
    check({tag, "_max"},     32'(out_max),     32'(e.mx));
    check({tag, "_count"},   32'(out_count),   32'(e.cnt));
    check({tag, "_all_eq"},  32'(out_all_eq),  32'(e.eq));
    check({tag, "_valid_s"}, 32'(out_valid_s), 32'd1);
    check({tag, "_count_s"}, 32'(out_count_s), 32'(e.cnt_s));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_out_min",   32'(out_min),    32'd0);
    check("rst_out_max",   32'(out_max),    32'd0);
    check("rst_out_count", 32'(out_count),  32'd0);
    check("rst_out_all_eq",32'(out_all_eq), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Mixed frame with out_ready asserted ahead of the result.
    out_ready = 1'b1;
    beat(4'd5, 1'b0); beat(4'd3, 1'b0); beat(4'd9, 1'b0); beat(4'd1, 1'b1);
    get_result("mixed");

    // Single-beat frame.
    beat(4'd7, 1'b1);
    get_result("single");

    // All-equal frame.
    beat(4'd4, 1'b0); beat(4'd4, 1'b0); beat(4'd4, 1'b1);
    get_result("equal");

    // Backpressure: result held, inputs ignored while in HOLD.
    beat(4'd6, 1'b0); beat(4'd11, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 4'd2;
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_min",   32'(out_min),   32'(sb[0].mn));
      check("bp_out_max",   32'(out_max),   32'(sb[0].mx));
      check("bp_out_count", 32'(out_count), 32'(sb[0].cnt));
    end
    in_valid = 1'b0;
    get_result("bp");

    // Reset mid-frame discards the partial frame.
    beat(4'd9, 1'b0); beat(4'd2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_first = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    beat(4'd6, 1'b0); beat(4'd8, 1'b1);
    get_result("after_rst");

    // Ten-beat frame: saturates the 3-bit counter instance.
    beat(4'd3, 1'b0); beat(4'd12, 1'b0); beat(4'd5, 1'b0); beat(4'd0, 1'b0);
    beat(4'd15, 1'b0); beat(4'd7, 1'b0); beat(4'd7, 1'b0); beat(4'd1, 1'b0);
    beat(4'd9, 1'b0); beat(4'd4, 1'b1);
    get_result("sat");

    // Sign-sensitive frame.
    beat(4'hF, 1'b0); beat(4'h7, 1'b0); beat(4'h8, 1'b1);
`ifdef MIN_MAX_TRACKER_SIGNED_EN
    check("sign_min_const", 32'(out_min), 32'h8);
    check("sign_max_const", 32'(out_max), 32'h7);
`else
    check("sign_min_const", 32'(out_min), 32'h7);
    check("sign_max_const", 32'(out_max), 32'hF);
`endif
    get_result("sign");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/min_max_tracker.md
Name: min_max_tracker

Overview:
- Streaming stage that feeds a 4-bit magnitude comparator with sample pairs and consumes its less/greater/equal flags.
- Accepts a frame of DATA_W-bit samples over a valid/ready handshake and tracks the running minimum and maximum.
- Presents one result per frame: min, max, sample count and an all-equal flag, with its own valid/ready handshake.
- Sits between a sample source and downstream range/threshold logic.

Parameters:
- DATA_W, 4, sample width in bits.
- CNT_W, 8, sample-count width; the count saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  sample valid
- in_ready  output  1  stage can accept a sample
- in_data  input  DATA_W  sample value
- in_last  input  1  final sample of the frame
- out_valid  output  1  frame result valid
- out_ready  input  1  consumer accepts the result
- out_min  output  DATA_W  frame minimum
- out_max  output  DATA_W  frame maximum
- out_count  output  CNT_W  samples in the frame (saturating)
- out_all_eq  output  1  every sample in the frame was equal

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state IDLE, out_valid=0, out_min=0, out_max=0, out_count=0, out_all_eq=0. in_ready=1 from the cycle after reset.
- Reset mid-frame or mid-HOLD discards all partial or held data. No result is emitted.
- States:
  - IDLE: waiting for the first sample.
  - ACCUM: inside a frame.
  - HOLD: result presented.
- in_ready is combinational from state: 1 in IDLE and ACCUM, 0 in HOLD. A beat is accepted when in_valid & in_ready; in_data and in_last are ignored otherwise.
- IDLE, on accept:
  - min=max=in_data, count=1, all_eq=1.
  - Next state is HOLD if in_last, else ACCUM.
- ACCUM, on accept:
  - Comparator operands are (in_data, min) and (in_data, max).
  - less-than vs min: min<=in_data.
  - greater-than vs max: max<=in_data.
  - Equal: no update.
  - all_eq clears if in_data != min or in_data != max.
  - count<=count+1, saturating at 2^CNT_W-1.
  - in_last: next state HOLD.
- HOLD:
  - out_valid=1; the out_* values include the last beat.
  - Latency: out_valid rises in the cycle after the in_last beat is accepted.
  - Outputs stay stable while out_ready=0.
  - On out_valid & out_ready, the next state is IDLE and out_valid=0 next cycle.
  - Output registers keep their values until the next frame's first accepted beat.
- Throughput: at least one HOLD cycle between frames; in_ready=0 during that cycle. There is no bypass.
- out_min, out_max, out_count and out_all_eq are defined only while out_valid=1; they may change during ACCUM.
- Single-beat frame (in_last on the first beat): IDLE->HOLD directly, with count=1 and all_eq=1.
- Comparison is unsigned unless the optional feature below is enabled.

Optional Feature:
- Macro: MIN_MAX_TRACKER_SIGNED_EN.
- Defined: samples and min/max comparisons are two's complement over DATA_W bits.
- Undefined: unsigned comparison.
- Ports and timing are identical in both builds.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_HOLD=2'd2;
  - default widths DATA_W=4 and CNT_W=8.
- One sub-module is natural: mag_cmp.
  - Purely combinational, DATA_W-parameterised.
  - Outputs lt/gt/eq; the signedness is selected by the macro.
  - Instantiated twice: once against min, once against max.

Test Plan:
- Unsigned frame 5,3,9,1(last), out_ready=1 -> out_valid one cycle after the last accept; min=1, max=9, count=4, all_eq=0; IDLE the following cycle.
- Single beat 7 with in_last -> min=7, max=7, count=1, all_eq=1. Frame 4,4,4(last) -> all_eq=1, count=3.
- Backpressure: hold out_ready=0 for 5 cycles after a result, driving in_valid=1 and in_data=2 -> in_ready=0, outputs unchanged and input ignored; out_ready=1 -> out_valid drops next cycle.
- Reset mid-frame after samples 9,2, then frame 6,8(last) -> no result for the partial frame; result is min=6, max=8, count=2.
- CNT_W=3, 10-beat frame -> count=7 (saturated), min/max still correct.
- With MIN_MAX_TRACKER_SIGNED_EN defined, frame 4'hF, 4'h7, 4'h8(last) -> min=4'h8 (-8), max=4'h7. Without it -> min=4'h7, max=4'hF.
